// File: rtl/cond_sub.sv
// Bit-serial conditional subtractor.
// Produces result = (in0 >= in1) ? in0 - in1 : in0 for unsigned operands,
// one bit per enabled clock, least significant bit first. The final borrow
// out of the serial subtraction selects between the difference and the
// original minuend, and also drives the ge flag.
module cond_sub #(
   parameter int DATA_WIDTH = 1025
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  start_sub,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   output logic                  busy,
   output logic                  done_sub,
   output logic                  ge,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] a_sh;
   logic [DATA_WIDTH-1:0] b_sh;
   logic [DATA_WIDTH-1:0] keep;
   logic [DATA_WIDTH-1:0] diff_sh;
   logic                  borrow;
   logic [CNT_W-1:0]      cnt;

   logic                  bit_a;
   logic                  bit_b;
   logic                  bit_d;
   logic                  borrow_next;
   logic [DATA_WIDTH-1:0] diff_next;

   // One full-subtractor step on the current low bits of the shifted operands.
   always_comb begin
      bit_a       = a_sh[0];
      bit_b       = b_sh[0];
      bit_d       = bit_a ^ bit_b ^ borrow;
      borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
      diff_next   = {bit_d, diff_sh[DATA_WIDTH-1:1]};
   end

   // Control FSM and datapath registers; reset wins over ce, ce gates everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         keep     <= '0;
         diff_sh  <= '0;
         borrow   <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done_sub <= 1'b0;
         ge       <= 1'b0;
         result   <= '0;
      end else if (ce) begin
         case (state)
            S_IDLE: begin
               if (start_sub) begin
                  a_sh    <= in0;
                  b_sh    <= in1;
                  keep    <= in0;
                  diff_sh <= '0;
                  borrow  <= 1'b0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               borrow  <= borrow_next;
               diff_sh <= diff_next;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  ge       <= ~borrow_next;
                  result   <= borrow_next ? keep : diff_next;
                  done_sub <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               done_sub <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cond_sub.sv
// Testbench for cond_sub: a narrow 8-bit instance for directed vectors and
// multi-cycle corner cases, and a default-width instance for random
// operands checked against a plain-arithmetic reference model.
module tb_cond_sub;

   localparam int NW = 8;
   localparam int WW = 1025;

   logic clk;
   logic rst;

   logic          ce8, start8, busy8, done8, ge8;
   logic [NW-1:0] a8, b8, res8;

   logic          ceW, startW, busyW, doneW, geW;
   logic [WW-1:0] aW, bW, resW;

   int nChecks;
   int nFails;

   typedef struct {
      logic [NW-1:0] a;
      logic [NW-1:0] b;
      logic [NW-1:0] res;
      logic          ge;
   } vec_t;

   vec_t vecs[8];

   cond_sub #(.DATA_WIDTH(NW)) dutNarrow (
      .clk(clk), .rst(rst), .ce(ce8), .start_sub(start8),
      .in0(a8), .in1(b8), .busy(busy8), .done_sub(done8),
      .ge(ge8), .result(res8)
   );

   cond_sub dutWide (
      .clk(clk), .rst(rst), .ce(ceW), .start_sub(startW),
      .in0(aW), .in1(bW), .busy(busyW), .done_sub(doneW),
      .ge(geW), .result(resW)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WW-1:0] act,
                              input logic [WW-1:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (low 128 bits)",
                  name, act[127:0], exp[127:0]);
      end
   endtask

   // Reference: conditional subtraction straight from its definition.
   function automatic logic [WW:0] refModel(input logic [WW-1:0] x,
                                            input logic [WW-1:0] y);
      logic [WW-1:0] r;
      logic          g;
      g = (x >= y);
      r = g ? (x - y) : x;
      return {g, r};
   endfunction

   // Full operation on the narrow instance with ce held high.
   task automatic applyStimulus(input string tag, input logic [NW-1:0] x,
                                input logic [NW-1:0] y, input logic [NW-1:0] expRes,
                                input logic expGe);
      int cycles;
      a8 = x; b8 = y; ce8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = ~x; b8 = ~y;
      checkOutput({tag, "_busy"}, WW'(busy8), WW'(1));
      cycles = 0;
      while (!done8 && cycles < 40) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_latency"}, WW'(cycles), WW'(NW));
      checkOutput({tag, "_result"}, WW'(res8), WW'(expRes));
      checkOutput({tag, "_ge"}, WW'(ge8), WW'(expGe));
      tick();
      checkOutput({tag, "_done_clear"}, WW'(done8), WW'(0));
      checkOutput({tag, "_idle"}, WW'(busy8), WW'(0));
   endtask

   // Full operation on the wide instance, checked against the reference model.
   task automatic applyStimulusWide(input int idx, input logic [WW-1:0] x,
                                    input logic [WW-1:0] y);
      logic [WW:0] expv;
      int          cycles;
      expv = refModel(x, y);
      aW = x; bW = y; ceW = 1'b1; startW = 1'b1;
      tick();
      startW = 1'b0;
      aW = '0; bW = '1;
      cycles = 0;
      while (!doneW && cycles < WW + 50) begin
         tick();
         cycles++;
      end
      checkOutput($sformatf("wide%0d_latency", idx), WW'(cycles), WW'(WW));
      checkOutput($sformatf("wide%0d_result", idx), resW, expv[WW-1:0]);
      checkOutput($sformatf("wide%0d_ge", idx), WW'(geW), WW'(expv[WW]));
      tick();
      checkOutput($sformatf("wide%0d_idle", idx), WW'(busyW), WW'(0));
   endtask

   function automatic logic [WW-1:0] randWide();
      logic [WW+30:0] w;
      for (int i = 0; i < 33; i++) w[i*32 +: 32] = $urandom;
      return w[WW-1:0];
   endfunction

   // Main stimulus sequence.
   initial begin
      logic [WW-1:0] x, y;
      logic [NW:0]   e8;
      logic [NW-1:0] rx, ry;
      int            en, ticks, extra;
      logic          ceWas;

      nChecks = 0; nFails = 0;
      rst = 1'b1;
      ce8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
      ceW = 1'b0; startW = 1'b0; aW = '0; bW = '0;

      vecs[0] = '{a: 8'd200, b: 8'd57,  res: 8'd143, ge: 1'b1};
      vecs[1] = '{a: 8'd57,  b: 8'd200, res: 8'd57,  ge: 1'b0};
      vecs[2] = '{a: 8'd100, b: 8'd100, res: 8'd0,   ge: 1'b1};
      vecs[3] = '{a: 8'd255, b: 8'd254, res: 8'd1,   ge: 1'b1};
      vecs[4] = '{a: 8'd0,   b: 8'd255, res: 8'd0,   ge: 1'b0};
      vecs[5] = '{a: 8'd173, b: 8'd0,   res: 8'd173, ge: 1'b1};
      vecs[6] = '{a: 8'd0,   b: 8'd0,   res: 8'd0,   ge: 1'b1};
      vecs[7] = '{a: 8'd128, b: 8'd129, res: 8'd128, ge: 1'b0};

      tick(); tick();
      rst = 1'b0;
      checkOutput("rst_busy", WW'(busy8), WW'(0));
      checkOutput("rst_done", WW'(done8), WW'(0));
      checkOutput("rst_ge", WW'(ge8), WW'(0));
      checkOutput("rst_result", WW'(res8), WW'(0));
      checkOutput("rst_wide_result", resW, '0);

      for (int i = 0; i < 8; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ge);

      for (int i = 0; i < 20; i++) begin
         rx = NW'($urandom);
         ry = (i % 4 == 0) ? rx : NW'($urandom);
         e8 = refModel(WW'(rx), WW'(ry)) >> 0 == 0 ? '0 : {rx >= ry, (rx >= ry) ? rx - ry : rx};
         applyStimulus($sformatf("rnd%0d", i), rx, ry, e8[NW-1:0], e8[NW]);
      end

      // Stall and interference: random ce, inputs scrambled, start pulsed mid-run.
      a8 = 8'd200; b8 = 8'd57; ce8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      en = 0; ticks = 0;
      while (!done8 && ticks < 200) begin
         a8 = NW'($urandom); b8 = NW'($urandom);
         ce8 = 1'($urandom_range(0, 1));
         start8 = (en == 3) ? 1'b1 : 1'b0;
         ceWas = ce8;
         tick();
         ticks++;
         if (ceWas) en++;
      end
      start8 = 1'b0;
      checkOutput("stall_latency", WW'(en), WW'(NW));
      checkOutput("stall_result", WW'(res8), WW'(143));
      checkOutput("stall_ge", WW'(ge8), WW'(1));
      ce8 = 1'b0;
      tick(); tick();
      checkOutput("stall_done_hold", WW'(done8), WW'(1));
      ce8 = 1'b1;
      tick();
      checkOutput("stall_done_clear", WW'(done8), WW'(0));
      checkOutput("stall_idle", WW'(busy8), WW'(0));
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) extra++;
      end
      checkOutput("stall_single_done", WW'(1 + extra), WW'(1));

      // Reset part-way through a run, with ce low to show reset has priority.
      a8 = 8'd200; b8 = 8'd57; ce8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1; ce8 = 1'b0;
      tick();
      rst = 1'b0;
      checkOutput("midrst_busy", WW'(busy8), WW'(0));
      checkOutput("midrst_done", WW'(done8), WW'(0));
      checkOutput("midrst_ge", WW'(ge8), WW'(0));
      checkOutput("midrst_result", WW'(res8), WW'(0));
      ce8 = 1'b1;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 || busy8) extra++;
      end
      checkOutput("midrst_no_done", WW'(extra), WW'(0));
      applyStimulus("after_rst", 8'd57, 8'd57, 8'd0, 1'b1);

      // Default-width instance: random operands with a mix of relations.
      for (int i = 0; i < 30; i++) begin
         x = randWide();
         case (i % 4)
            0: y = x;
            1: y = x - WW'($urandom_range(0, 3));
            2: y = x + WW'($urandom_range(1, 3));
            default: y = randWide();
         endcase
         applyStimulusWide(i, x, y);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
